// File: rtl/fractal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fractal_pkg
// Description : Shared coordinate format and dispatcher state encoding for
//               the Mandelbrot solver pool.
// Revision    : 1.0 - initial release
// ============================================================================
package fractal_pkg;

  localparam int COORD_WIDTH = 27;
  localparam int FRAC_BITS   = 20;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker: lowest requesting index at
//               or after the pointer, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import fractal_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic             o_valid
);

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    // Upper pass covers indices >= pointer; lower pass only fires on wrap.
    for (int i = 0; i < N; i++) begin
      if (!o_valid && i_req[i] && (PTR_W'(i) >= i_ptr)) begin
        o_grant[i] = 1'b1;
        o_valid    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!o_valid && i_req[i]) begin
        o_grant[i] = 1'b1;
        o_valid    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : pixel_dispatcher
// Description : Walks a frame in raster order, issuing one pixel job per cycle
//               to the next ready solver and tracking outstanding work.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_dispatcher
  import fractal_pkg::*;
#(
  parameter int NUM_SOLVERS = 4,
  parameter int NUM_COLUMNS = 640,
  parameter int NUM_ROWS    = 480,
  parameter int WIDTH       = COORD_WIDTH,
  parameter int ADDR_WIDTH  = 19,
  parameter int CNT_WIDTH   = 7
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] min_x,
  input  logic signed [WIDTH-1:0] min_y,
  input  logic signed [WIDTH-1:0] dx,
  input  logic signed [WIDTH-1:0] dy,
  input  logic [NUM_SOLVERS-1:0]  solver_ready,
  input  logic [NUM_SOLVERS-1:0]  solver_done,
  output logic [NUM_SOLVERS-1:0]  solver_start,
  output logic signed [WIDTH-1:0] job_x,
  output logic signed [WIDTH-1:0] job_y,
  output logic [ADDR_WIDTH-1:0]   job_addr,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int c_PTR_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam int c_COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
  localparam int c_ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  localparam logic [c_COL_W-1:0] c_LAST_COL    = c_COL_W'(NUM_COLUMNS - 1);
  localparam logic [c_ROW_W-1:0] c_LAST_ROW    = c_ROW_W'(NUM_ROWS - 1);
  localparam logic [c_PTR_W-1:0] c_LAST_SOLVER = c_PTR_W'(NUM_SOLVERS - 1);

  disp_state_t             r_state;
  disp_state_t             w_state_next;
  logic [c_COL_W-1:0]      r_col;
  logic [c_ROW_W-1:0]      r_row;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic signed [WIDTH-1:0] r_cur_x;
  logic signed [WIDTH-1:0] r_cur_y;
  logic signed [WIDTH-1:0] r_min_x;
  logic signed [WIDTH-1:0] r_dx;
  logic signed [WIDTH-1:0] r_dy;
  logic [c_PTR_W-1:0]      r_rr_ptr;
  logic [c_PTR_W-1:0]      w_grant_idx;
  logic [c_PTR_W-1:0]      w_rr_ptr_next;
  logic [CNT_WIDTH-1:0]    r_outstanding;
  logic [CNT_WIDTH-1:0]    w_outstanding_next;
  logic [CNT_WIDTH-1:0]    w_done_cnt;
  logic [NUM_SOLVERS-1:0]  w_eligible;
  logic [NUM_SOLVERS-1:0]  w_grant;
  logic                    w_grant_valid;
  logic                    w_issue;
  logic                    w_active;
  logic                    w_last_col;
  logic                    w_last_pixel;

  // Ready drops one cycle after a strobe, so last cycle's grantee is masked.
  assign w_eligible = solver_ready & ~solver_start;

  rr_arbiter #(
    .N     (NUM_SOLVERS),
    .PTR_W (c_PTR_W)
  ) u_arbiter (
    .i_req   (w_eligible),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_valid (w_grant_valid)
  );

  assign w_active     = (r_state == ST_DISPATCH) || (r_state == ST_DRAIN);
  assign w_issue      = (r_state == ST_DISPATCH) && w_grant_valid;
  assign w_last_col   = (r_col == c_LAST_COL);
  assign w_last_pixel = w_last_col && (r_row == c_LAST_ROW);

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      if (w_grant[i]) w_grant_idx = c_PTR_W'(i);
    end
    w_rr_ptr_next = (w_grant_idx == c_LAST_SOLVER) ? '0 : w_grant_idx + 1'b1;
  end

  always_comb begin
    w_done_cnt = '0;
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      w_done_cnt = w_done_cnt + CNT_WIDTH'(solver_done[i]);
    end
  end

  assign w_outstanding_next = w_active ? (r_outstanding + CNT_WIDTH'(w_issue) - w_done_cnt)
                                       : r_outstanding;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    frame_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        busy = 1'b1;
        if (w_issue && w_last_pixel) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_outstanding_next == '0) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        frame_done   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      solver_start  <= '0;
      job_x         <= '0;
      job_y         <= '0;
      job_addr      <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_addr        <= '0;
      r_cur_x       <= '0;
      r_cur_y       <= '0;
      r_min_x       <= '0;
      r_dx          <= '0;
      r_dy          <= '0;
      r_rr_ptr      <= '0;
      r_outstanding <= '0;
    end else begin
      solver_start  <= '0;
      r_outstanding <= w_outstanding_next;
      if ((r_state == ST_IDLE) && start) begin
        // min_y only seeds cur_y; rows advance from there by dy.
        r_min_x <= min_x;
        r_dx    <= dx;
        r_dy    <= dy;
        r_cur_x <= min_x;
        r_cur_y <= min_y;
        r_col   <= '0;
        r_row   <= '0;
        r_addr  <= '0;
      end else if (w_issue) begin
        solver_start <= w_grant;
        job_x        <= r_cur_x;
        job_y        <= r_cur_y;
        job_addr     <= r_addr;
        r_rr_ptr     <= w_rr_ptr_next;
        r_addr       <= r_addr + 1'b1;
        if (w_last_col) begin
          r_col   <= '0;
          r_cur_x <= r_min_x;
          r_row   <= r_row + 1'b1;
          r_cur_y <= r_cur_y + r_dy;
        end else begin
          r_col   <= r_col + 1'b1;
          r_cur_x <= r_cur_x + r_dx;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_dispatcher
// Description : Self-checking bench: scoreboarded 1-solver raster frame plus
//               a cycle-vector table on a 4-solver 4x3 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_dispatcher;

  typedef struct {
    longint x;
    longint y;
    longint addr;
  } job_t;

  typedef struct {
    bit         rst_n;
    bit         start;
    int         mx;
    logic [3:0] ready;
    logic [3:0] done;
    logic [3:0] exp_strobe;
    bit         exp_busy;
    bit         exp_fd;
    int         exp_addr;
  } vec_t;

  logic clock;
  int   n_checks = 0;
  int   n_pass   = 0;

  // single-solver 3x2 instance
  logic              reset1, start1;
  logic signed [26:0] min_x1, min_y1, dx1, dy1;
  logic [0:0]        ready1, done1, strobe1;
  logic signed [26:0] job_x1, job_y1;
  logic [18:0]       job_addr1;
  logic              busy1, fd1;

  // four-solver 4x3 instance
  logic              reset4, start4;
  logic signed [26:0] min_x4, min_y4, dx4, dy4;
  logic [3:0]        ready4, done4, strobe4;
  logic signed [26:0] job_x4, job_y4;
  logic [18:0]       job_addr4;
  logic              busy4, fd4;

  job_t sb1[$];
  int   fd_count1 = 0;
  int   issued1   = 0;
  int   model1    = 0;

  pixel_dispatcher #(
    .NUM_SOLVERS(1), .NUM_COLUMNS(3), .NUM_ROWS(2),
    .WIDTH(27), .ADDR_WIDTH(19), .CNT_WIDTH(7)
  ) dut1 (
    .clock(clock), .reset(reset1), .start(start1),
    .min_x(min_x1), .min_y(min_y1), .dx(dx1), .dy(dy1),
    .solver_ready(ready1), .solver_done(done1), .solver_start(strobe1),
    .job_x(job_x1), .job_y(job_y1), .job_addr(job_addr1),
    .busy(busy1), .frame_done(fd1)
  );

  pixel_dispatcher #(
    .NUM_SOLVERS(4), .NUM_COLUMNS(4), .NUM_ROWS(3),
    .WIDTH(27), .ADDR_WIDTH(19), .CNT_WIDTH(7)
  ) dut4 (
    .clock(clock), .reset(reset4), .start(start4),
    .min_x(min_x4), .min_y(min_y4), .dx(dx4), .dy(dy4),
    .solver_ready(ready4), .solver_done(done4), .solver_start(strobe4),
    .job_x(job_x4), .job_y(job_y4), .job_addr(job_addr4),
    .busy(busy4), .frame_done(fd4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(bit rst_n, bit st, int mx, logic [3:0] rdy,
                              logic [3:0] dn, logic [3:0] es, bit eb, bit ef, int ea);
    vec_t v;
    v.rst_n = rst_n; v.start = st; v.mx = mx; v.ready = rdy; v.done = dn;
    v.exp_strobe = es; v.exp_busy = eb; v.exp_fd = ef; v.exp_addr = ea;
    return v;
  endfunction

  // Solver model for dut1: done echoed 5 cycles after each strobe.
  initial begin : p_solver1
    int   cnt = 0;
    int   nneg = 0;
    int   last_done_neg = -100;
    job_t e;
    ready1 = 1'b1;
    done1  = 1'b0;
    forever begin
      @(negedge clock);
      nneg++;
      if (strobe1[0]) model1++;
      if (done1[0]) begin
        model1--;
        check("dut1_no_underflow", longint'(model1 >= 0), 1);
      end
      if (strobe1[0]) begin
        issued1++;
        if (sb1.size() == 0) begin
          check("dut1_unexpected_strobe", 1, 0);
        end else begin
          e = sb1.pop_front();
          check("dut1_job_x", longint'(job_x1), e.x);
          check("dut1_job_y", longint'(job_y1), e.y);
          check("dut1_job_addr", longint'(job_addr1), e.addr);
        end
      end
      if (fd1) begin
        fd_count1++;
        check("dut1_frame_done_delay", nneg, last_done_neg + 1);
      end
      done1 = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          done1 = 1'b1;
          ready1 = 1'b1;
          last_done_neg = nneg;
        end
      end
      if (strobe1[0]) begin
        ready1 = 1'b0;
        cnt = 5;
      end
    end
  end

  initial begin : p_main
    job_t exp1[6];
    vec_t vecs[$];
    vec_t v;
    int   model4 = 0;
    bit   prev_busy = 1'b0;
    longint ex, ey;

    reset1 = 1'b0; reset4 = 1'b0; start1 = 1'b0; start4 = 1'b0;
    min_x1 = 27'(-2097152); min_y1 = 27'(-1048576); dx1 = 27'(31775); dy1 = 27'(31775);
    min_x4 = 27'(100); min_y4 = 27'(1000); dx4 = 27'(10); dy4 = 27'(-7);
    ready4 = 4'h0; done4 = 4'h0;
    repeat (3) @(negedge clock);
    reset1 = 1'b1; reset4 = 1'b1;
    @(negedge clock);

    check("rst_strobe4", longint'(strobe4), 0);
    check("rst_busy4", longint'(busy4), 0);
    check("rst_fd4", longint'(fd4), 0);
    check("rst_job_x4", longint'(job_x4), 0);
    check("rst_job_addr4", longint'(job_addr4), 0);
    check("rst_outstanding4", longint'(dut4.r_outstanding), 0);
    check("rst_strobe1", longint'(strobe1), 0);

    // Raster frame on the single-solver instance.
    exp1[0] = '{-2097152, -1048576, 0};
    exp1[1] = '{-2065377, -1048576, 1};
    exp1[2] = '{-2033602, -1048576, 2};
    exp1[3] = '{-2097152, -1016801, 3};
    exp1[4] = '{-2065377, -1016801, 4};
    exp1[5] = '{-2033602, -1016801, 5};
    for (int k = 0; k < 6; k++) sb1.push_back(exp1[k]);
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    for (int t = 0; t < 400 && fd_count1 == 0; t++) @(negedge clock);
    check("dut1_frame_done_seen", longint'(fd_count1 > 0), 1);
    repeat (5) @(negedge clock);
    check("dut1_frame_done_count", fd_count1, 1);
    check("dut1_jobs_issued", issued1, 6);
    check("dut1_scoreboard_empty", sb1.size(), 0);
    check("dut1_outstanding_end", longint'(dut1.r_outstanding), 0);

    // Frame A: all ready, mid-frame start ignored, done overlaps issue, drain.
    vecs.push_back(mk(1, 1, 100, 4'hF, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h0, 4'h1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h0, 4'h2, 1, 0, 1));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h0, 4'h4, 1, 0, 2));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h0, 4'h8, 1, 0, 3));
    vecs.push_back(mk(1, 1, 0,   4'hF, 4'h0, 4'h1, 1, 0, 4));
    vecs.push_back(mk(1, 0, 0,   4'hF, 4'h3, 4'h2, 1, 0, 5));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h0, 4'h4, 1, 0, 6));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h0, 4'h8, 1, 0, 7));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h5, 4'h1, 1, 0, 8));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h0, 4'h2, 1, 0, 9));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h0, 4'h4, 1, 0, 10));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'hA, 4'h8, 1, 0, 11));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'hF, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h3, 4'h0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h1, 4'h0, 0, 0, 0));
    // Frame B: only solver 2 ready, then reset at pixel 3, then a fresh frame.
    vecs.push_back(mk(1, 1, 100, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 100, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 100, 4'h4, 4'h0, 4'h4, 1, 0, 0));
    vecs.push_back(mk(1, 0, 100, 4'h4, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 100, 4'h4, 4'h0, 4'h4, 1, 0, 1));
    vecs.push_back(mk(1, 0, 100, 4'h4, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 100, 4'h4, 4'h0, 4'h4, 1, 0, 2));
    vecs.push_back(mk(1, 0, 100, 4'h0, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 100, 4'h4, 4'h0, 4'h4, 1, 0, 3));
    vecs.push_back(mk(0, 0, 100, 4'hF, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h0, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 100, 4'hF, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h0, 4'h1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 100, 4'hF, 4'h0, 4'h2, 1, 0, 1));
    vecs.push_back(mk(0, 0, 100, 4'h0, 4'h0, 4'h0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      reset4 = v.rst_n;
      start4 = v.start;
      min_x4 = 27'(v.mx);
      ready4 = v.ready;
      done4  = v.done;
      @(negedge clock);
      if (!v.rst_n) begin
        model4 = 0;
      end else if (prev_busy) begin
        model4 = model4 + ((v.exp_strobe != 4'h0) ? 1 : 0) - $countones(v.done);
      end
      prev_busy = v.exp_busy;
      check($sformatf("v%0d_strobe", i), longint'(strobe4), longint'(v.exp_strobe));
      check($sformatf("v%0d_busy", i), longint'(busy4), longint'(v.exp_busy));
      check($sformatf("v%0d_frame_done", i), longint'(fd4), longint'(v.exp_fd));
      check($sformatf("v%0d_outstanding", i), longint'(dut4.r_outstanding), model4);
      if (v.exp_strobe != 4'h0) begin
        ex = 100 + 10 * (v.exp_addr % 4);
        ey = 1000 - 7 * (v.exp_addr / 4);
        check($sformatf("v%0d_job_addr", i), longint'(job_addr4), v.exp_addr);
        check($sformatf("v%0d_job_x", i), longint'(job_x4), ex);
        check($sformatf("v%0d_job_y", i), longint'(job_y4), ey);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
